mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/memarb_pkg.sv | 33 +++
 rtl/mem_port_arbiter_rr_pick.sv | 36 +++
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// -----------------------------------------------------------------------------
// memarb_pkg
// Shared definitions for the memory port arbiter: requester count and index
// constants, FSM state encoding, and one-hot/index helpers.
// -----------------------------------------------------------------------------
package memarb_pkg;

  localparam int NREQ = 3;

  typedef logic [1:0] req_idx_t;

  localparam req_idx_t REQ_CPU = 2'd0;
  localparam req_idx_t REQ_VGA = 2'd1;
  localparam req_idx_t REQ_KEY = 2'd2;

  typedef enum logic {
    ARB = 1'b0,  // open arbitration every cycle
    OWN = 1'b1   // one requester holds the port via lock
  } arb_state_e;

  function automatic req_idx_t onehot_to_idx(input logic [NREQ-1:0] oh);
    req_idx_t idx;
    idx = REQ_CPU;
    if (oh[REQ_VGA]) idx = REQ_VGA;
    if (oh[REQ_KEY]) idx = REQ_KEY;
    return idx;
  endfunction

  function automatic logic [NREQ-1:0] idx_to_onehot(input req_idx_t idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Circular priority search: returns the first requesting bit found when
// scanning upward from start_i, wrapping around.
//
// Ports:
//   req_i   in  NREQ  request vector
//   start_i in  2     index where the search begins
//   gnt_o   out NREQ  one-hot pick (all zero when req_i is zero)
// -----------------------------------------------------------------------------
module rr_pick
  import memarb_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  req_idx_t        start_i,
  output logic [NREQ-1:0] gnt_o
);

  logic     found;
  req_idx_t idx;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    gnt_o = '0;
    found = 1'b0;
    idx   = REQ_CPU;
    for (int k = 0; k < NREQ; k++) begin
      idx = req_idx_t'((int'(start_i) + k) % NREQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one synchronous RAM port among CPU (0), VGA reader (1) and keyboard
// writer (2). One access per cycle, round-robin arbitration with an optional
// lock that lets a requester keep the port for up to LOCK_MAX consecutive
// grants. Read data returns one cycle after the read grant.
//
// Build option: define MEMARB_FIXED_PRIO_EN to replace round-robin with fixed
// priority CPU > VGA > keyboard (lock behaviour unchanged).
//
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   req/we/lock [3]   per-requester request, write enable, keep-port request
//   addr_in [3*AW]    packed addresses, requester i at [i*AW +: AW]
//   wdata_in [3*DW]   packed write data, requester i at [i*DW +: DW]
//   gnt [3]           one-hot grant, access happens this cycle
//   rvalid [3]        one-hot, rdata valid for that requester this cycle
//   rdata [DW]        read data broadcast
//   ram_addr/ram_data/ram_we  RAM port A controls
//   ram_q [DW]        RAM port A read data (one-cycle latency)
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import memarb_pkg::*;
#(
  parameter int AW       = 10,
  parameter int DW       = 16,
  parameter int LOCK_MAX = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ*AW-1:0] addr_in,
  input  logic [NREQ*DW-1:0] wdata_in,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_data,
  output logic               ram_we,
  input  logic [DW-1:0]      ram_q
);

  // Counter holds OWN-state grants; it never needs to exceed LOCK_MAX-2.
  localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

  arb_state_e       state_q, state_d;
  req_idx_t         owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             skip_q, skip_d;
  logic [NREQ-1:0]  rd_pend_q, rd_pend_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
`ifndef MEMARB_FIXED_PRIO_EN
  req_idx_t         ptr_q, ptr_d;
`endif

  logic [NREQ-1:0]  owner_bit, cand, pick, gnt_raw;
  logic             own_hold, any_gnt;
  req_idx_t         start, gidx;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;

  // Candidate set and search start.
  always_comb begin
    owner_bit = idx_to_onehot(owner_q);
    own_hold  = (state_q == OWN) && req[owner_q];
    cand      = req;
    // After a forced release the previous owner yields once, if anyone else wants the port.
    if (skip_q && ((req & ~owner_bit) != '0)) cand = req & ~owner_bit;
`ifdef MEMARB_FIXED_PRIO_EN
    start = REQ_CPU;
`else
    start = (ptr_q == REQ_KEY) ? REQ_CPU : req_idx_t'(ptr_q + 2'd1);
`endif
  end

  rr_pick u_pick (
    .req_i   (cand),
    .start_i (start),
    .gnt_o   (pick)
  );

  // An owner that stopped requesting loses the port in the same cycle, so
  // the others are arbitrated without a dead cycle.
  always_comb begin
    gnt_raw = own_hold ? owner_bit : pick;
    any_gnt = |gnt_raw;
    gidx    = onehot_to_idx(gnt_raw);
    case (gidx)
      REQ_VGA: begin
        sel_addr = addr_in[1*AW +: AW];
        sel_data = wdata_in[1*DW +: DW];
      end
      REQ_KEY: begin
        sel_addr = addr_in[2*AW +: AW];
        sel_data = wdata_in[2*DW +: DW];
      end
      default: begin
        sel_addr = addr_in[0 +: AW];
        sel_data = wdata_in[0 +: DW];
      end
    endcase
  end

  assign gnt      = Rst ? '0 : gnt_raw;
  assign ram_we   = ~Rst & any_gnt & we[gidx];
  assign ram_addr = Rst ? '0 : (any_gnt ? sel_addr : addr_q);
  assign ram_data = Rst ? '0 : (any_gnt ? sel_data : data_q);
  assign rvalid   = Rst ? '0 : rd_pend_q;
  assign rdata    = (rvalid != '0) ? ram_q : '0;

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    skip_d    = skip_q;
    rd_pend_d = (any_gnt && !we[gidx]) ? gnt_raw : '0;
    addr_d    = any_gnt ? sel_addr : addr_q;
    data_d    = any_gnt ? sel_data : data_q;
`ifndef MEMARB_FIXED_PRIO_EN
    ptr_d     = any_gnt ? gidx : ptr_q;
`endif

    if (!any_gnt) begin
      state_d = ARB;
    end else if (own_hold) begin
      skip_d = 1'b0;
      // The ARB grant that won the port is the first of the LOCK_MAX run,
      // so this grant completes the run when cnt_q reaches LOCK_MAX-2.
      if (!lock[owner_q]) begin
        state_d = ARB;
      end else if (int'(cnt_q) + 2 >= LOCK_MAX) begin
        state_d = ARB;
        skip_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      skip_d  = 1'b0;
      state_d = ARB;
      if (lock[gidx]) begin
        owner_d = gidx;
        if (LOCK_MAX > 1) begin
          state_d = OWN;
          cnt_d   = '0;
        end else begin
          skip_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (Rst) begin
      state_q   <= ARB;
      owner_q   <= REQ_CPU;
      cnt_q     <= '0;
      skip_q    <= 1'b0;
      rd_pend_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
`ifndef MEMARB_FIXED_PRIO_EN
      ptr_q     <= REQ_KEY;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      skip_q    <= skip_d;
      rd_pend_q <= rd_pend_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
`ifndef MEMARB_FIXED_PRIO_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter with a behavioural RAM. Each cycle
// the expected grant is given by the scenario; expected read results are
// pushed to a scoreboard and compared one cycle later against rvalid/rdata.
// Build option: MEMARB_FIXED_PRIO_EN selects the fixed-priority scenarios.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 16;

  typedef struct {
    logic [2:0]    rv;
    logic [DW-1:0] data;
  } rd_exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [2:0]          req, we, lock;
  logic [AW-1:0]       a [3];
  logic [DW-1:0]       d [3];
  logic [3*AW-1:0]     addr_in;
  logic [3*DW-1:0]     wdata_in;
  logic [2:0]          gnt, rvalid;
  logic [DW-1:0]       rdata, ram_data, ram_q;
  logic [AW-1:0]       ram_addr;
  logic                ram_we;

  logic [DW-1:0]       mem [0:(1<<AW)-1];
  logic [DW-1:0]       sh  [0:(1<<AW)-1];
  rd_exp_t             sb [$];
  logic [AW-1:0]       last_addr;
  logic [DW-1:0]       last_data;
  int                  n_pass = 0;
  int                  n_total = 0;

  assign addr_in  = {a[2], a[1], a[0]};
  assign wdata_in = {d[2], d[1], d[0]};

  always #5 clk = ~clk;

  // Behavioural synchronous RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  mem_port_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(16)) dut (
    .Clk      (clk),
    .Rst      (rst),
    .req      (req),
    .we       (we),
    .lock     (lock),
    .addr_in  (addr_in),
    .wdata_in (wdata_in),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_we   (ram_we),
    .ram_q    (ram_q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic set_in(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l);
    req  = r;
    we   = w;
    lock = l;
  endtask

  task automatic default_addr();
    a[0] = 10'h001; a[1] = 10'h002; a[2] = 10'h003;
    d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333;
  endtask

  // One clock cycle: check this cycle's outputs at the falling edge, then
  // advance past the rising edge.
  task automatic step(input string tag, input logic [2:0] exp_gnt);
    rd_exp_t e;
    int      gi;
    @(negedge clk);
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".rvalid"}, 32'(rvalid), 32'(e.rv));
      if (e.rv != 3'b000) check({tag, ".rdata"}, 32'(rdata), 32'(e.data));
    end else begin
      check({tag, ".rvalid"}, 32'(rvalid), 32'd0);
    end
    e.rv   = 3'b000;
    e.data = '0;
    if (exp_gnt != 3'b000) begin
      gi = (exp_gnt == 3'b001) ? 0 : (exp_gnt == 3'b010) ? 1 : 2;
      check({tag, ".ram_addr"}, 32'(ram_addr), 32'(a[gi]));
      check({tag, ".ram_data"}, 32'(ram_data), 32'(d[gi]));
      check({tag, ".ram_we"}, 32'(ram_we), 32'(we[gi]));
      last_addr = a[gi];
      last_data = d[gi];
      if (we[gi]) begin
        sh[a[gi]] = d[gi];
      end else begin
        e.rv   = exp_gnt;
        e.data = sh[a[gi]];
      end
    end else begin
      check({tag, ".ram_we"}, 32'(ram_we), 32'd0);
      check({tag, ".ram_addr_hold"}, 32'(ram_addr), 32'(last_addr));
      check({tag, ".ram_data_hold"}, 32'(ram_data), 32'(last_data));
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    set_in(3'b111, 3'b000, 3'b111);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst.gnt", 32'(gnt), 32'd0);
      check("rst.rvalid", 32'(rvalid), 32'd0);
      check("rst.rdata", 32'(rdata), 32'd0);
      check("rst.ram_we", 32'(ram_we), 32'd0);
      check("rst.ram_addr", 32'(ram_addr), 32'd0);
      check("rst.ram_data", 32'(ram_data), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    sb.delete();
    last_addr = '0;
    last_data = '0;
    set_in(3'b000, 3'b000, 3'b000);
  endtask

  // CPU write then VGA read of the same address.
  task automatic write_read_test();
    do_reset(1);
    default_addr();
    a[0] = 10'h005; d[0] = 16'hBEEF;
    set_in(3'b001, 3'b001, 3'b000);
    step("wr.cpu", 3'b001);
    a[1] = 10'h005;
    set_in(3'b010, 3'b000, 3'b000);
    step("rd.vga", 3'b010);
    set_in(3'b000, 3'b000, 3'b000);
    step("rd.vga.ret", 3'b000);
    default_addr();
  endtask

  // CPU holds lock with VGA waiting: 16 CPU grants, then VGA.
  task automatic lock_max_test();
    do_reset(2);
    set_in(3'b011, 3'b000, 3'b001);
    for (int i = 1; i <= 16; i++) step($sformatf("lock.c%0d", i), 3'b001);
    step("lock.c17", 3'b010);
    set_in(3'b000, 3'b000, 3'b000);
    step("lock.drain", 3'b000);
  endtask

  // Reset pulsed right after a VGA read grant drops that read.
  task automatic reset_drop_test();
    set_in(3'b010, 3'b000, 3'b000);
    step("rstdrop.vga", 3'b010);
    do_reset(1);
    step("rstdrop.idle", 3'b000);
    set_in(3'b111, 3'b000, 3'b000);
    step("rstdrop.first", 3'b001);
    set_in(3'b000, 3'b000, 3'b000);
    step("rstdrop.drain", 3'b000);
  endtask

`ifndef MEMARB_FIXED_PRIO_EN
  task automatic rr_tests();
    do_reset(2);
    // Rotation from reset, all reads.
    set_in(3'b111, 3'b000, 3'b000);
    step("rot.0", 3'b001);
    step("rot.1", 3'b010);
    step("rot.2", 3'b100);
    step("rot.3", 3'b001);
    // Idle gap keeps pointer and RAM address.
    set_in(3'b000, 3'b000, 3'b000);
    for (int i = 0; i < 3; i++) step($sformatf("idle.%0d", i), 3'b000);
    set_in(3'b111, 3'b000, 3'b000);
    step("idle.resume", 3'b010);
    // we/lock on non-requesting bits ignored.
    set_in(3'b010, 3'b101, 3'b101);
    step("ign.vga", 3'b010);
    set_in(3'b011, 3'b000, 3'b000);
    step("ign.next", 3'b001);
    // Owner blocks others, releases after dropping lock.
    set_in(3'b001, 3'b000, 3'b001);
    step("own.enter", 3'b001);
    set_in(3'b011, 3'b000, 3'b001);
    step("own.hold", 3'b001);
    set_in(3'b011, 3'b000, 3'b000);
    step("own.unlock", 3'b001);
    step("own.after", 3'b010);
    // Owner dropping req frees the port in the same cycle.
    set_in(3'b100, 3'b000, 3'b100);
    step("drop.enter", 3'b100);
    set_in(3'b011, 3'b000, 3'b000);
    step("drop.other", 3'b001);
    // Keyboard write then CPU read of the same address.
    a[2] = 10'h009; d[2] = 16'h1234; a[0] = 10'h009;
    set_in(3'b100, 3'b100, 3'b000);
    step("kwr", 3'b100);
    set_in(3'b001, 3'b000, 3'b000);
    step("krd", 3'b001);
    set_in(3'b000, 3'b000, 3'b000);
    step("krd.ret", 3'b000);
    default_addr();
  endtask
`else
  task automatic fixed_tests();
    do_reset(2);
    set_in(3'b111, 3'b000, 3'b000);
    for (int i = 0; i < 4; i++) step($sformatf("fix.%0d", i), 3'b001);
    set_in(3'b000, 3'b000, 3'b000);
    step("fix.drain", 3'b000);
  endtask
`endif

  initial begin
    rst = 1'b1;
    set_in(3'b000, 3'b000, 3'b000);
    default_addr();
    last_addr = '0;
    last_data = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 16'hA000 ^ DW'(i);
      sh[i]  = 16'hA000 ^ DW'(i);
    end
    #1;
`ifndef MEMARB_FIXED_PRIO_EN
    rr_tests();
`else
    fixed_tests();
`endif
    write_read_test();
    lock_max_test();
    reset_drop_test();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
